// File: rtl/prm_edge_chk_sched.sv
// Sequencer that walks a range of roadmap edges, fetches each edge code, presents it
// to the obstacle-checker bank and returns per-edge hit results over valid/ready.
module prm_edge_chk_sched #(
  parameter int NUM_CHK = 8,
  parameter int EDGE_AW = 10,
  parameter int CODE_W  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [EDGE_AW-1:0] edge_base,
  input  logic [EDGE_AW:0]   edge_cnt,
  input  logic [NUM_CHK-1:0] obs_en,
  output logic               code_rd,
  output logic [EDGE_AW-1:0] code_addr,
  input  logic [CODE_W-1:0]  code_data,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [EDGE_AW-1:0] res_edge,
  output logic [NUM_CHK-1:0] res_hits,
  output logic               res_blocked,
  output logic [EDGE_AW:0]   blocked_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [EDGE_AW-1:0] EDGE_ONE = {{(EDGE_AW-1){1'b0}}, 1'b1};
  localparam logic [EDGE_AW:0]   REM_ONE  = {{EDGE_AW{1'b0}}, 1'b1};
  localparam logic [EDGE_AW:0]   REM_ZERO = '0;

  state_t               state;
  logic [EDGE_AW-1:0]   cur;
  logic [EDGE_AW:0]     rem;
  logic [NUM_CHK-1:0]   en;
  logic [NUM_CHK-1:0]   hits;
  logic [EDGE_AW-1:0]   cur_next;

  assign hits     = chk_mask & en;
  assign cur_next = cur + EDGE_ONE;

  // code_rd/code_addr are registered on entry to FETCH so the strobe lines up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur         <= '0;
      rem         <= '0;
      en          <= '0;
      code_rd     <= 1'b0;
      code_addr   <= '0;
      chk_code    <= '0;
      res_valid   <= 1'b0;
      res_edge    <= '0;
      res_hits    <= '0;
      res_blocked <= 1'b0;
      blocked_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      code_rd <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cur         <= edge_base;
              rem         <= edge_cnt;
              en          <= obs_en;
              blocked_cnt <= '0;
              busy        <= 1'b1;
              if (edge_cnt != REM_ZERO) begin
                state     <= S_FETCH;
                code_rd   <= 1'b1;
                code_addr <= edge_base;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            chk_code <= code_data;
            state    <= S_EVAL;
          end
          S_EVAL: begin
            res_hits    <= hits;
            res_blocked <= |hits;
            res_edge    <= cur;
            res_valid   <= 1'b1;
            state       <= S_HOLD;
          end
          S_HOLD: begin
            if (res_ready) begin
              res_valid   <= 1'b0;
              blocked_cnt <= blocked_cnt + {{EDGE_AW{1'b0}}, res_blocked};
              cur         <= cur_next;
              rem         <= rem - REM_ONE;
              if (rem == REM_ONE) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state     <= S_FETCH;
                code_rd   <= 1'b1;
                code_addr <= cur_next;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Scoreboard bench for prm_edge_chk_sched: directed runs push expected results,
// a negedge monitor pops and compares on every accepted handshake.
module tb_prm_edge_chk_sched;

  localparam int NUM_CHK = 8;
  localparam int EDGE_AW = 10;
  localparam int CODE_W  = 15;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [EDGE_AW-1:0] edge_base;
  logic [EDGE_AW:0]   edge_cnt;
  logic [NUM_CHK-1:0] obs_en;
  logic               code_rd;
  logic [EDGE_AW-1:0] code_addr;
  logic [CODE_W-1:0]  code_data;
  logic [CODE_W-1:0]  chk_code;
  logic [NUM_CHK-1:0] chk_mask;
  logic               res_valid;
  logic               res_ready;
  logic [EDGE_AW-1:0] res_edge;
  logic [NUM_CHK-1:0] res_hits;
  logic               res_blocked;
  logic [EDGE_AW:0]   blocked_cnt;
  logic               busy;
  logic               done;

  typedef struct {
    logic [EDGE_AW-1:0] e;
    logic [NUM_CHK-1:0] h;
    logic               b;
  } exp_t;

  exp_t               sbq[$];
  logic [EDGE_AW-1:0] addrLog[$];
  logic [CODE_W-1:0]  mem[1024];
  int                 checks = 0;
  int                 passes = 0;
  int                 cyc = 0;
  int                 startCyc = 0;
  int                 rdCount = 0;
  int                 busyCycles = 0;
  int                 doneCount = 0;

  prm_edge_chk_sched #(.NUM_CHK(NUM_CHK), .EDGE_AW(EDGE_AW), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .edge_base(edge_base), .edge_cnt(edge_cnt), .obs_en(obs_en),
    .code_rd(code_rd), .code_addr(code_addr), .code_data(code_data),
    .chk_code(chk_code), .chk_mask(chk_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_edge(res_edge),
    .res_hits(res_hits), .res_blocked(res_blocked),
    .blocked_cnt(blocked_cnt), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Code memory with one-cycle read latency.
  always @(posedge clk) if (code_rd) code_data <= mem[code_addr];

  // Checker bank model: 0 flags 0x4F80, 1 and 5 flag 0x7FFF, 3 flags 0x1234.
  always_comb begin
    chk_mask    = '0;
    chk_mask[0] = (chk_code == 15'h4F80);
    chk_mask[1] = (chk_code == 15'h7FFF);
    chk_mask[5] = (chk_code == 15'h7FFF);
    chk_mask[3] = (chk_code == 15'h1234);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (code_rd) begin
      rdCount++;
      addrLog.push_back(code_addr);
    end
    if (busy) busyCycles++;
    if (done) doneCount++;
    if (rst_n && res_valid && res_ready && !abort) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected_result", {res_edge, res_hits, res_blocked}, 64'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        checkOutput("sb_result", {res_edge, res_hits, res_blocked}, {x.e, x.h, x.b});
      end
    end
  end

  task automatic pushExp(input logic [EDGE_AW-1:0] e, input logic [NUM_CHK-1:0] h, input logic b);
    exp_t x;
    x.e = e; x.h = h; x.b = b;
    sbq.push_back(x);
  endtask

  task automatic applyStimulus(input logic [EDGE_AW-1:0] base, input logic [EDGE_AW:0] cnt,
                               input logic [NUM_CHK-1:0] en);
    @(posedge clk); #1;
    edge_base = base; edge_cnt = cnt; obs_en = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    startCyc = cyc;
  endtask

  task automatic waitDone(input int n, output int doneAt);
    doneAt = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) begin
        doneAt = cyc;
        return;
      end
    end
  endtask

  task automatic waitValid(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (res_valid) return;
    end
    checkOutput(name, 64'd0, 64'd1);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {code_rd, code_addr, chk_code, res_valid, res_edge, res_hits,
                       res_blocked, blocked_cnt, busy, done}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneAt;
    int r0, b0, d0;
    logic [63:0] snap;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 15'h4F80; mem[6] = 15'h0000; mem[7] = 15'h7FFF;
    mem[10] = 15'h1234;
    mem[10'h3FE] = 15'h4F80; mem[10'h3FF] = 15'h0000;
    mem[0] = 15'h7FFF; mem[1] = 15'h1234;
    code_data = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    edge_base = '0; edge_cnt = '0; obs_en = '0;
    #3;
    checkAllZero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic run, ready held high.
    res_ready = 1'b1;
    pushExp(10'd5, 8'h01, 1'b1);
    pushExp(10'd6, 8'h00, 1'b0);
    pushExp(10'd7, 8'h22, 1'b1);
    applyStimulus(10'd5, 11'd3, 8'hFF);
    waitDone(40, doneAt);
    checkOutput("basic_done_time", doneAt, startCyc + 12);
    checkOutput("basic_blocked_cnt", blocked_cnt, 11'd2);
    @(negedge clk);
    checkOutput("basic_idle_after", {busy, done}, 2'b00);

    // Reset asserted while in LOAD.
    applyStimulus(10'd5, 11'd3, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrun_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0 = rdCount;
    repeat (5) @(posedge clk);
    #1;
    checkAllZero("midrun_reset_stays_idle");
    checkOutput("midrun_reset_no_fetch", rdCount, r0);

    // Backpressure with a masked-off hit.
    res_ready = 1'b0;
    pushExp(10'd10, 8'h00, 1'b0);
    applyStimulus(10'd10, 11'd1, 8'h01);
    waitValid("bp_valid_timeout", 20);
    snap = {res_valid, res_edge, res_hits, res_blocked};
    checkOutput("bp_first_result", snap, {1'b1, 10'd10, 8'h00, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_stable", {res_valid, res_edge, res_hits, res_blocked}, snap);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_accepted", {res_valid, done}, 2'b01);
    checkOutput("bp_blocked_cnt", blocked_cnt, 11'd0);

    // Address wrap.
    @(posedge clk); #1;
    addrLog.delete();
    pushExp(10'h3FE, 8'h01, 1'b1);
    pushExp(10'h3FF, 8'h00, 1'b0);
    pushExp(10'h000, 8'h02, 1'b1);
    pushExp(10'h001, 8'h08, 1'b1);
    applyStimulus(10'h3FE, 11'd4, 8'h0F);
    waitDone(60, doneAt);
    checkOutput("wrap_done_time", doneAt, startCyc + 16);
    checkOutput("wrap_addr_count", addrLog.size(), 4);
    if (addrLog.size() == 4)
      checkOutput("wrap_addr_seq", {addrLog[0], addrLog[1], addrLog[2], addrLog[3]},
                  {10'h3FE, 10'h3FF, 10'h000, 10'h001});
    checkOutput("wrap_blocked_cnt", blocked_cnt, 11'd3);

    // Zero-length run.
    @(posedge clk); #1;
    r0 = rdCount; b0 = busyCycles;
    applyStimulus(10'd20, 11'd0, 8'hFF);
    @(negedge clk);
    checkOutput("zero_done_at_t1", {done, busy, cyc == startCyc}, 3'b111);
    checkOutput("zero_blocked_cleared", blocked_cnt, 11'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_busy_cycles", busyCycles - b0, 1);
    checkOutput("zero_no_code_rd", rdCount - r0, 0);

    // Abort in HOLD with a same-cycle handshake.
    res_ready = 1'b0;
    pushExp(10'd5, 8'h01, 1'b1);
    applyStimulus(10'd5, 11'd3, 8'hFF);
    waitValid("abort_valid1_timeout", 20);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    waitValid("abort_valid2_timeout", 20);
    d0 = doneCount;
    @(posedge clk); #1;
    abort = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", {busy, res_valid, done}, 3'b000);
    checkOutput("abort_blocked_frozen", blocked_cnt, 11'd1);
    @(posedge clk); #1;
    checkOutput("abort_no_done", doneCount - d0, 0);
    res_ready = 1'b1;
    pushExp(10'd7, 8'h22, 1'b1);
    applyStimulus(10'd7, 11'd1, 8'hFF);
    waitDone(30, doneAt);
    checkOutput("abort_restart_done_time", doneAt, startCyc + 4);
    checkOutput("abort_restart_blocked", blocked_cnt, 11'd1);

    // Start during FETCH is ignored.
    @(posedge clk); #1;
    pushExp(10'd5, 8'h01, 1'b1);
    pushExp(10'd6, 8'h00, 1'b0);
    applyStimulus(10'd5, 11'd2, 8'hFF);
    edge_base = 10'h100; edge_cnt = 11'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(40, doneAt);
    checkOutput("ignore_done_time", doneAt, startCyc + 8);
    checkOutput("ignore_blocked_cnt", blocked_cnt, 11'd1);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("sb_all_consumed", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
